// File: rtl/updown_counter_pkg.sv
// ============================================================================
// Module      : updown_counter_pkg
// Description : Shared types and next-count arithmetic for updown_counter_param.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package updown_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Wide enough for a 32-bit count plus carry, and for MODULUS = 2**32.
  localparam int CNT_WIDE_W = 33;
  typedef logic [CNT_WIDE_W-1:0] cnt_wide_t;

  typedef struct packed {
    cnt_wide_t value;
    logic      boundary;
  } next_t;

  // Caller guarantees count < modulus and step < modulus.
  function automatic next_t next_count(
    input cnt_wide_t count,
    input cnt_wide_t step,
    input dir_e      dir,
    input cnt_wide_t modulus,
    input logic      sat
  );
    next_t     r;
    cnt_wide_t max_v;
    cnt_wide_t sum;
    max_v      = modulus - cnt_wide_t'(1);
    sum        = count + step;
    r.value    = count;
    r.boundary = 1'b0;
    if (dir == DIR_UP) begin
      if (sum > max_v) begin
        r.boundary = 1'b1;
        r.value    = sat ? max_v : (sum - modulus);
      end else begin
        r.value = sum;
      end
    end else if (step > count) begin
      r.boundary = 1'b1;
      r.value    = sat ? '0 : (count + modulus - step);
    end else begin
      r.value = count - step;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/updown_counter_param.sv
// ============================================================================
// Module      : updown_counter_param
// Description : Parametrised up/down counter with wrap/saturate, load and
//               boundary-event pulse plus sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_counter_param
  import updown_counter_pkg::*;
#(
  parameter int        WIDTH    = 8,
  parameter logic [32:0] MODULUS = 33'd1 << WIDTH,
  parameter int        STEP_W   = 4,
  parameter bit        SATURATE = 1'b0,
  parameter logic [32:0] INIT   = 33'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              bound_pulse,
  output logic              ovf,
  output logic              unf,
  output logic              step_err,
  output logic              zero
);

  localparam cnt_wide_t        c_max    = MODULUS - cnt_wide_t'(1);
  localparam logic [WIDTH-1:0] c_max_n  = c_max[WIDTH-1:0];
  localparam logic [WIDTH-1:0] c_init_n = INIT[WIDTH-1:0];
  localparam logic             c_mode   = SATURATE ? MODE_SAT : MODE_WRAP;

  logic [WIDTH-1:0] count_q, count_d;
  logic             bound_q, bound_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             step_err_q, step_err_d;

  cnt_wide_t step_wide;
  next_t     nc;
  logic      unused_nc_hi;

  assign step_wide    = cnt_wide_t'(step);
  assign unused_nc_hi = ^nc.value[CNT_WIDE_W-1:WIDTH];

  always_comb begin
    nc         = next_count(cnt_wide_t'(count_q), step_wide, dir_e'(up_down), MODULUS, c_mode);
    count_d    = count_q;
    bound_d    = 1'b0;
    step_err_d = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;

    if (clr_flags) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end

    if (load) begin
      count_d = (cnt_wide_t'(load_val) > c_max) ? c_max_n : load_val;
    end else if (en) begin
      // An oversized step is rejected outright rather than reduced modulo.
      if (step_wide >= MODULUS) begin
        step_err_d = 1'b1;
      end else begin
        count_d = nc.value[WIDTH-1:0];
        bound_d = nc.boundary;
        if (nc.boundary) begin
          if (up_down) ovf_d = 1'b1;
          else         unf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= c_init_n;
      bound_q    <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      bound_q    <= bound_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      step_err_q <= step_err_d;
    end
  end

  assign count       = count_q;
  assign bound_pulse = bound_q;
  assign ovf         = ovf_q;
  assign unf         = unf_q;
  assign step_err    = step_err_q;
  assign zero        = (count_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_updown_counter_param.sv
// ============================================================================
// Module      : tb_updown_counter_param
// Description : Scoreboard bench driving three counter configurations in
//               parallel against a plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_counter_param;

  localparam int NI = 3;
  localparam int MODS  [NI] = '{8, 10, 10};
  localparam int WDS   [NI] = '{3, 4, 4};
  localparam int SWS   [NI] = '{3, 4, 4};
  localparam int SATS  [NI] = '{0, 1, 0};
  localparam int INITS [NI] = '{0, 2, 0};

  typedef struct packed {
    logic [NI-1:0][3:0] cnt;
    logic [NI-1:0]      bp;
    logic [NI-1:0]      ovf;
    logic [NI-1:0]      unf;
    logic [NI-1:0]      se;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, up_down, load, clr_flags;
  logic [3:0] step, load_val;

  logic [2:0] cnt0;
  logic [3:0] cnt1, cnt2;
  logic [NI-1:0] a_bp, a_ovf, a_unf, a_se, a_zero;
  logic [3:0]    a_cnt [NI];

  exp_t exp_q[$];
  int   m_cnt [NI];
  bit   m_ovf [NI];
  bit   m_unf [NI];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_chk_cycles = 0;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(3), .MODULUS(8), .STEP_W(3), .SATURATE(1'b0), .INIT(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .step(step[2:0]), .load(load),
    .load_val(load_val[2:0]), .clr_flags(clr_flags), .count(cnt0), .bound_pulse(a_bp[0]),
    .ovf(a_ovf[0]), .unf(a_unf[0]), .step_err(a_se[0]), .zero(a_zero[0]));

  updown_counter_param #(.WIDTH(4), .MODULUS(10), .STEP_W(4), .SATURATE(1'b1), .INIT(2)) u1 (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .step(step), .load(load),
    .load_val(load_val), .clr_flags(clr_flags), .count(cnt1), .bound_pulse(a_bp[1]),
    .ovf(a_ovf[1]), .unf(a_unf[1]), .step_err(a_se[1]), .zero(a_zero[1]));

  updown_counter_param #(.WIDTH(4), .MODULUS(10), .STEP_W(4), .SATURATE(1'b0), .INIT(0)) u2 (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .step(step), .load(load),
    .load_val(load_val), .clr_flags(clr_flags), .count(cnt2), .bound_pulse(a_bp[2]),
    .ovf(a_ovf[2]), .unf(a_unf[2]), .step_err(a_se[2]), .zero(a_zero[2]));

  assign a_cnt[0] = {1'b0, cnt0};
  assign a_cnt[1] = cnt1;
  assign a_cnt[2] = cnt2;

  task automatic check(input string name, input int inst, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s inst=%0d cycle=%0d actual=%0d required=%0d", name, inst, n_chk_cycles, act, req);
    end
  endtask

  // Reference: count as a plain integer, boundaries detected by leaving [0, MODULUS-1].
  task automatic model_step(input bit r, input bit ld, input int lv, input bit e,
                            input bit ud, input int st, input bit clr);
    exp_t x;
    x = '0;
    for (int i = 0; i < NI; i++) begin
      int mx, s, v, t;
      bit ov, un, se;
      mx = MODS[i] - 1;
      s  = st % (1 << SWS[i]);
      v  = lv % (1 << WDS[i]);
      ov = 0; un = 0; se = 0;
      if (r) begin
        m_cnt[i] = INITS[i];
        m_ovf[i] = 0;
        m_unf[i] = 0;
      end else begin
        if (ld) begin
          m_cnt[i] = (v > mx) ? mx : v;
        end else if (e) begin
          if (s >= MODS[i]) se = 1;
          else begin
            t = ud ? m_cnt[i] + s : m_cnt[i] - s;
            if (t > mx) begin
              ov = 1;
              m_cnt[i] = (SATS[i] != 0) ? mx : t - MODS[i];
            end else if (t < 0) begin
              un = 1;
              m_cnt[i] = (SATS[i] != 0) ? 0 : t + MODS[i];
            end else begin
              m_cnt[i] = t;
            end
          end
        end
        if (clr) begin m_ovf[i] = 0; m_unf[i] = 0; end
        if (ov) m_ovf[i] = 1;
        if (un) m_unf[i] = 1;
      end
      x.cnt[i] = 4'(m_cnt[i]);
      x.bp[i]  = ov | un;
      x.ovf[i] = m_ovf[i];
      x.unf[i] = m_unf[i];
      x.se[i]  = se;
    end
    exp_q.push_back(x);
  endtask

  // Called at a negedge; applies inputs, scores the following posedge, returns at next negedge.
  task automatic cyc(input bit r, input bit ld, input int lv, input bit e,
                     input bit ud, input int st, input bit clr);
    rst = r; load = ld; load_val = 4'(lv); en = e; up_down = ud; step = 4'(st); clr_flags = clr;
    @(posedge clk);
    model_step(r, ld, lv, e, ud, st, clr);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_chk_cycles++;
        for (int i = 0; i < NI; i++) begin
          check("count",       i, int'(a_cnt[i]),  int'(e.cnt[i]));
          check("zero",        i, int'(a_zero[i]), int'(e.cnt[i] == 4'd0));
          check("bound_pulse", i, int'(a_bp[i]),   int'(e.bp[i]));
          check("ovf",         i, int'(a_ovf[i]),  int'(e.ovf[i]));
          check("unf",         i, int'(a_unf[i]),  int'(e.unf[i]));
          check("step_err",    i, int'(a_se[i]),   int'(e.se[i]));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    rst = 1'b1; en = 1'b0; up_down = 1'b0; load = 1'b0; clr_flags = 1'b0;
    step = '0; load_val = '0;
    for (int i = 0; i < NI; i++) begin m_cnt[i] = INITS[i]; m_ovf[i] = 0; m_unf[i] = 0; end
    @(negedge clk);

    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) cyc(0, 0, 0, 1, 1, 1, 0);   // up through the wrap
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 0, 1, 0);   // down from 0
    cyc(0, 1, 8, 1, 0, 5, 0);                                // load 8
    cyc(0, 0, 0, 1, 1, 3, 0);
    cyc(0, 0, 0, 1, 1, 3, 0);                                // repeat at clamp
    cyc(0, 1, 14, 0, 0, 0, 1);                               // oversize load
    cyc(0, 0, 0, 1, 1, 2, 0);
    cyc(0, 0, 0, 1, 1, 9, 1);                                // clr with overflow
    cyc(0, 0, 0, 1, 1, 12, 0);                               // oversize step
    cyc(0, 0, 0, 1, 0, 0, 0);                                // step 0
    cyc(0, 0, 0, 0, 1, 3, 1);                                // disabled, clear
    cyc(0, 1, 5, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 9, 0);
    cyc(0, 1, 5, 0, 0, 0, 0);
    cyc(1, 1, 7, 1, 1, 3, 0);                                // reset beats load
    cyc(0, 1, 9, 0, 0, 0, 0);                                // exact MAX
    cyc(0, 0, 0, 1, 0, 9, 0);                                // exact 0

    for (int k = 0; k < 400; k++) begin
      bit r, ld, e, ud, clr;
      int st;
      r   = ($urandom_range(0, 59) == 0);
      ld  = ($urandom_range(0, 7) == 0);
      e   = ($urandom_range(0, 3) != 0);
      ud  = $urandom_range(0, 1) != 0;
      clr = ($urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      cyc(r, ld, $urandom_range(0, 15), e, ud, st, clr);
    end

    cyc(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("queue_drained", -1, exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised successor to the 3-bit up/down counter: configurable width, modulus, step size and wrap/saturate mode.
- Adds enable, synchronous parallel load, and boundary-event signalling (registered pulse plus sticky flags).
- Used as the general counting primitive for timers, address generators and the lab counter exercises.

Parameters:
- WIDTH, 8, count width in bits (2..32).
- MODULUS, 2**WIDTH, number of count states; legal range 2..2**WIDTH; MAX = MODULUS-1.
- STEP_W, 4, width of step input; STEP_W <= WIDTH.
- SATURATE, 0, 0 = wrap at boundaries, 1 = clamp at 0 / MAX.
- INIT, 0, count value after reset; must be < MODULUS.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; when low, count holds.
- up_down  in  1  1 = count up, 0 = count down.
- step  in  STEP_W  increment/decrement amount per enabled cycle; 0 = hold.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- clr_flags  in  1  clears sticky flags.
- count  out  WIDTH  current count, registered.
- bound_pulse  out  1  registered; high for exactly the cycle following an update that crossed or clamped at a boundary.
- ovf  out  1  sticky overflow (up past MAX).
- unf  out  1  sticky underflow (down past 0).
- step_err  out  1  registered; high for one cycle after an enabled update with step >= MODULUS.
- zero  out  1  combinational, count == 0.

Behaviour:
- Reset (rst=1 at posedge): count=INIT; bound_pulse, ovf, unf, step_err = 0. Reset overrides every other input. Reset mid-sequence discards any pending update.
- Priority per edge: rst > load > en. With en=0 and load=0, count holds and both pulses go low.
- Load: count <= (load_val > MAX) ? MAX : load_val. No flags are set. bound_pulse and step_err = 0. A load ignores en, up_down and step.
- Enabled update: arithmetic is done in WIDTH+1 bits so no intermediate value truncates.
  - Up, wrap mode: sum = count+step. If sum > MAX, count <= sum - MODULUS, ovf <= 1, bound_pulse <= 1.
  - Up, saturate mode: if sum > MAX, count <= MAX, ovf <= 1, bound_pulse <= 1.
  - Down, step > count, wrap mode: count <= count + MODULUS - step, unf <= 1, bound_pulse <= 1.
  - Down, step > count, saturate mode: count <= 0, unf <= 1, bound_pulse <= 1.
  - Exactly reaching MAX or 0 is not a boundary event.
  - In saturate mode, a further step while already at MAX (up) or at 0 (down) re-fires bound_pulse and re-sets the flag.
- step >= MODULUS: count holds, step_err <= 1 for one cycle, no other flags change.
- step = 0 with en=1: count holds, no events.
- Latency: count, bound_pulse and step_err reflect the inputs sampled at the previous edge (one cycle). zero follows count combinationally.
- Sticky flags: clr_flags clears ovf and unf. If a new event and clr_flags occur in the same cycle, the set wins. Load does not clear the flags.
- Non-power-of-two MODULUS: count never leaves 0..MAX.

Decomposition:
- Package updown_counter_pkg holds:
  - typedef dir_e {DIR_DOWN=0, DIR_UP=1};
  - mode constants MODE_WRAP / MODE_SAT;
  - function next_count(count, step, dir, modulus, sat) returning {value, boundary} for reuse by the bench scoreboard.
- No sub-module; the datapath and flag registers stay in one module.

Test Plan:
- WIDTH=3, MODULUS=8, wrap, step=1, up, 9 enabled cycles from reset -> count 0,1,…,7,0,1. bound_pulse high in the single cycle count shows 0 after 7. ovf=1 thereafter.
- Same config, down from 0, step=1 -> count 7 on first edge. unf=1, bound_pulse for one cycle. Then 6,5.
- WIDTH=4, MODULUS=10, SATURATE=1, load 8, up step=3 -> count 9 (clamped), ovf=1, bound_pulse=1. A further step gives count 9 and bound_pulse=1 again.
- WIDTH=4, MODULUS=10, wrap, load_val=14 -> count 9. Then up step=2 -> count 1, ovf=1. Assert clr_flags and an overflow in the same cycle -> ovf stays 1.
- MODULUS=10, step=12 (STEP_W=4), en=1 -> count unchanged, step_err pulses one cycle, ovf/unf unchanged. step=0 -> hold, no pulses.
- Counting at 5 with ovf=1, assert rst together with load=1 -> next edge count=INIT=0, all flags 0. load ignored.
